// File: rtl/sparse_pkg.sv
// Shared constants, FSM state type and helpers for the 4-bit sparse
// activation encoder.
package sparse_pkg;

    localparam int ACT_W = 4;
    localparam int LANES = 4;
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // True when exactly one lane of the mask is still pending.
    function automatic logic popcount_is_one(input logic [LANES-1:0] mask);
        int cnt;
        cnt = 0;
        for (int k = 0; k < LANES; k++) begin
            cnt += int'(mask[k]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/sparse_lsb_pick.sv
// Lowest-set-bit picker: returns the index of the lowest set bit of a lane
// mask and whether any bit is set. Purely combinational.
module sparse_lsb_pick
    import sparse_pkg::*;
#(
    parameter int N = LANES,
    parameter int W = IDX_W
)
(
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         any_set
);

    // Scan from the top lane down so the lowest set lane is the final writer.
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) begin
                idx     = W'(k);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_act_encoder_4b.sv
// Sparse compressor for groups of four 4-bit activations. Each accepted group
// is replayed as one beat per nonzero lane, in ascending lane order, as a
// (value, lane index) pair; an all-zero group produces a single (0, 0) beat.
//
// Build option SPARSE_ENC_MASK_EN: when defined, adds out_mask, the nonzero
// bitmap of the group being emitted (zero while idle).
//
//   state | meaning
//   IDLE  | no group held, in_ready=1
//   EMIT  | group held, presenting beat for lowest pending lane
module sparse_act_encoder_4b
    import sparse_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ACT_W-1:0] in_act,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACT_W-1:0]       out_val,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last
`ifdef SPARSE_ENC_MASK_EN
    ,
    output logic [LANES-1:0]       out_mask
`endif
);

    state_t                 state_q;
    state_t                 state_d;
    logic [LANES*ACT_W-1:0] group_q;
    logic [LANES-1:0]       pending_q;
    logic [LANES-1:0]       nz_in;
    logic [LANES-1:0]       clr_bit;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   emit;
    logic                   last_beat;
    logic                   beat_fire;
    logic                   accept;

    sparse_lsb_pick #(
        .N (LANES),
        .W (IDX_W)
    ) u_pick (
        .mask    (pending_q),
        .idx     (pick_idx),
        .any_set (pick_any)
    );

    // Handshake terms shared by the FSM and the datapath.
    always_comb begin
        emit      = (state_q == EMIT);
        // An empty pending mask while emitting is the all-zero group's beat.
        last_beat = popcount_is_one(pending_q) || !pick_any;
        beat_fire = emit && out_ready;
        accept    = in_valid && in_ready;
    end

    // Nonzero-lane bitmap of the incoming group.
    always_comb begin
        nz_in = '0;
        for (int k = 0; k < LANES; k++) begin
            nz_in[k] = |in_act[k*ACT_W +: ACT_W];
        end
    end

    // One-hot of the lane being emitted, used to retire it on handshake.
    always_comb begin
        clr_bit = '0;
        if (pick_any) begin
            clr_bit[pick_idx] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a group accepted on the last-beat handshake keeps EMIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (beat_fire && last_beat) begin
                    state_d = accept ? EMIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: beat fields come straight from registers, zeroed when idle.
    always_comb begin
        out_valid = 1'b0;
        out_val   = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        in_ready  = !emit || (beat_fire && last_beat);
        if (emit) begin
            out_valid = 1'b1;
            out_idx   = pick_idx;
            out_val   = group_q[int'(pick_idx)*ACT_W +: ACT_W];
            out_last  = last_beat;
        end
    end

    // Group and pending-lane registers: load on accept, retire one lane per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            group_q   <= '0;
            pending_q <= '0;
        end else if (accept) begin
            group_q   <= in_act;
            pending_q <= nz_in;
        end else if (beat_fire) begin
            pending_q <= pending_q & ~clr_bit;
            if (last_beat) begin
                group_q <= '0;
            end
        end
    end

`ifdef SPARSE_ENC_MASK_EN
    logic [LANES-1:0] mask_q;

    // Full bitmap of the held group; stays constant until the group finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= nz_in;
        end else if (beat_fire && last_beat) begin
            mask_q <= '0;
        end
    end

    assign out_mask = mask_q;
`endif

endmodule

// File: tb/tb_sparse_act_encoder_4b.sv
// Self-checking bench for sparse_act_encoder_4b: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_sparse_act_encoder_4b;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_act;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_val;
    logic [1:0]  out_idx;
    logic        out_last;
`ifdef SPARSE_ENC_MASK_EN
    logic [3:0]  out_mask;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_val[$];
    logic [1:0] exp_idx[$];
    logic       exp_last[$];
    logic [3:0] exp_mask;

    sparse_act_encoder_4b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .out_idx   (out_idx),
        .out_last  (out_last)
`ifdef SPARSE_ENC_MASK_EN
        ,
        .out_mask  (out_mask)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: list the nonzero lanes in ascending order.
    function automatic void model_push(input logic [15:0] act);
        int lanes[$];
        logic [3:0] nib;
        exp_mask = '0;
        for (int k = 0; k < 4; k++) begin
            nib = act[k*4 +: 4];
            if (nib != 4'd0) begin
                lanes.push_back(k);
                exp_mask[k] = 1'b1;
            end
        end
        if (lanes.size() == 0) begin
            exp_val.push_back(4'd0);
            exp_idx.push_back(2'd0);
            exp_last.push_back(1'b1);
        end else begin
            foreach (lanes[i]) begin
                nib = act[lanes[i]*4 +: 4];
                exp_val.push_back(nib);
                exp_idx.push_back(2'(lanes[i]));
                exp_last.push_back(i == lanes.size() - 1);
            end
        end
    endfunction

    function automatic logic [15:0] rand_group();
        logic [15:0] a;
        a = '0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                a[k*4 +: 4] = 4'($urandom_range(1, 15));
            end
        end
        return a;
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_act = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b val=%h idx=%0d last=%b expected all zero",
                     out_valid, out_val, out_idx, out_last);
        end
`ifdef SPARSE_ENC_MASK_EN
        checks++;
        if (out_mask !== 4'h0) begin
            failures++;
            $display("FAIL reset_mask: got %h expected 0", out_mask);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        in_act = 16'h3050; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 4'h5, 2'd1, 1'b0}) begin
            failures++;
            $display("FAIL basic_beat0: got v=%b val=%h idx=%0d last=%b expected 1,5,1,0",
                     out_valid, out_val, out_idx, out_last);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_ready0: got %b expected 0", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 4'h3, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL basic_beat1: got v=%b val=%h idx=%0d last=%b expected 1,3,3,1",
                     out_valid, out_val, out_idx, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready1: got %b expected 1", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_zero;
        @(negedge clk);
        in_act = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 4'h0, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL zero_beat: got v=%b val=%h idx=%0d last=%b expected 1,0,0,1",
                     out_valid, out_val, out_idx, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_single: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_all_ones;
        @(negedge clk);
        in_act = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 4'hF, 2'(i), (i == 3)}) begin
                failures++;
                $display("FAIL ones_beat%0d: got v=%b val=%h idx=%0d last=%b expected 1,f,%0d,%0d",
                         i, out_valid, out_val, out_idx, out_last, i, (i == 3));
            end
`ifdef SPARSE_ENC_MASK_EN
            checks++;
            if (out_mask !== 4'hF) begin
                failures++;
                $display("FAIL ones_mask%0d: got %h expected f", i, out_mask);
            end
`endif
            @(negedge clk);
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ones_done: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        in_act = 16'h0700; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({out_valid, out_val, out_idx, out_last, in_ready} !== {1'b1, 4'h7, 2'd2, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b val=%h idx=%0d last=%b rdy=%b expected 1,7,2,1,0",
                         c, out_valid, out_val, out_idx, out_last, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last, in_ready} !== {1'b1, 4'h7, 2'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL bp_accept: got v=%b val=%h idx=%0d last=%b rdy=%b expected 1,7,2,1,1",
                     out_valid, out_val, out_idx, out_last, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_act = 16'h0001; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_act = 16'h1000;
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last, in_ready} !== {1'b1, 4'h1, 2'd0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_beat0: got v=%b val=%h idx=%0d last=%b rdy=%b expected 1,1,0,1,1",
                     out_valid, out_val, out_idx, out_last, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 4'h1, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL b2b_beat1: got v=%b val=%h idx=%0d last=%b expected 1,1,3,1",
                     out_valid, out_val, out_idx, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_act = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_idx} !== {1'b1, 2'd1}) begin
            failures++;
            $display("FAIL rmid_second: got v=%b idx=%0d expected 1,1", out_valid, out_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_drop: got out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rmid_release: got v=%b rdy=%b expected 0,1", out_valid, in_ready);
        end
        in_act = 16'h0020; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_val, out_idx, out_last} !== {1'b1, 4'h2, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL rmid_next: got v=%b val=%h idx=%0d last=%b expected 1,2,1,1",
                     out_valid, out_val, out_idx, out_last);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_done: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        bit          chained;
        int          cyc;
        chained = 1'b0;
        a = '0;
        for (int g = 0; g < 60; g++) begin
            if (!chained) begin
                @(negedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_idle%0d: got v=%b rdy=%b expected 0,1", g, out_valid, in_ready);
                end
                a = rand_group();
                in_act = a; in_valid = 1'b1; out_ready = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            in_valid = 1'b0;
            model_push(a);
            chained = 1'b0;
            cyc = 0;
            while (exp_val.size() > 0 && cyc < 100) begin
                cyc++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_ready && exp_last[0] && g < 59 && $urandom_range(0, 1) == 1) begin
                    a = rand_group();
                    in_act = a; in_valid = 1'b1; chained = 1'b1;
                end else begin
                    in_valid = !(out_ready && exp_last[0]) && ($urandom_range(0, 2) == 0);
                    in_act = 16'($urandom);
                end
                #1;
                checks++;
                if ({out_valid, out_val, out_idx, out_last} !== {1'b1, exp_val[0], exp_idx[0], exp_last[0]}) begin
                    failures++;
                    $display("FAIL rand_beat g%0d: got v=%b val=%h idx=%0d last=%b expected 1,%h,%0d,%b",
                             g, out_valid, out_val, out_idx, out_last, exp_val[0], exp_idx[0], exp_last[0]);
                end
                checks++;
                if (in_ready !== (out_ready && exp_last[0])) begin
                    failures++;
                    $display("FAIL rand_ready g%0d: got %b expected %b", g, in_ready, (out_ready && exp_last[0]));
                end
`ifdef SPARSE_ENC_MASK_EN
                checks++;
                if (out_mask !== exp_mask) begin
                    failures++;
                    $display("FAIL rand_mask g%0d: got %h expected %h", g, out_mask, exp_mask);
                end
`endif
                @(negedge clk);
                if (out_ready) begin
                    void'(exp_val.pop_front());
                    void'(exp_idx.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            if (exp_val.size() > 0) begin
                checks++;
                failures++;
                $display("FAIL rand_timeout g%0d: got %0d beats outstanding expected 0", g, exp_val.size());
                exp_val.delete(); exp_idx.delete(); exp_last.delete();
                chained = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
